// File: rtl/mulshift_pkg.sv
// mulshift_pkg: shared encodings for the iterative multiply/shift sequencer.
package mulshift_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        MUL_RUN,
        SHF_RUN,
        FINISH
    } state_t;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_SHIFT = 2'b01;

    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

endpackage

// File: rtl/seq_shift_step.sv
// seq_shift_step: combinational single-position shifter (sll/srl/sra/ror).
module seq_shift_step
    import mulshift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  logic [1:0]       shift_type,
    input  logic             sign,
    output logic [WIDTH-1:0] result
);

    assign result = shift_type == SH_SLL ? {value[WIDTH-2:0], 1'b0}
                  : {shift_type == SH_SRL ? 1'b0 : shift_type == SH_SRA ? sign : value[0],
                     value[WIDTH-1:1]};

endmodule

// File: rtl/mulshift_sequencer.sv
// mulshift_sequencer: one-bit-per-clock multiply / one-position-per-clock shift engine.
// MULSHIFT_EARLY_TERM_EN ends a multiply once the remaining multiplier bits are zero.
module mulshift_sequencer
    import mulshift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic             BUSYWAIT,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT
);

    state_t           state, nxt;
    // val is the multiplicand in MUL and the shifting value in SHIFT; ctl is the
    // multiplier in MUL and the untouched shift control word in SHIFT.
    logic [WIDTH-1:0] val, ctl, acc, acc_nxt, step, res_nxt;
    logic [CNT_W-1:0] cnt, n_load;
    logic             sign, launch_zero, mul_last, mul_skip;

    seq_shift_step #(.WIDTH(WIDTH)) u_step (
        .value     (val),
        .shift_type(ctl[5:4]),
        .sign      (sign),
        .result    (step)
    );

    assign acc_nxt = ctl[0] ? acc + val : acc;

`ifdef MULSHIFT_EARLY_TERM_EN
    assign mul_last = (ctl >> 1) == '0;
    assign mul_skip = DATA2 == '0;
`else
    assign mul_last = cnt == CNT_W'(1);
    assign mul_skip = 1'b0;
`endif

    always_comb begin
        n_load      = OP == OP_MUL ? CNT_W'(WIDTH) : OP == OP_SHIFT ? DATA2[CNT_W-1:0] : '0;
        launch_zero = OP[1] || (OP == OP_SHIFT && DATA2[CNT_W-1:0] == '0) || (OP == OP_MUL && mul_skip);
        res_nxt     = state == MUL_RUN ? acc_nxt : state == SHF_RUN ? step : OP == OP_SHIFT ? DATA1 : '0;
        nxt         = state;
        BUSYWAIT    = 1'b0;
        DONE        = 1'b0;
        case (state)
            IDLE: begin
                BUSYWAIT = START;
                if (START)
                    nxt = launch_zero ? FINISH : OP == OP_MUL ? MUL_RUN : SHF_RUN;
            end
            MUL_RUN: begin
                BUSYWAIT = 1'b1;
                if (mul_last)
                    nxt = FINISH;
            end
            SHF_RUN: begin
                BUSYWAIT = 1'b1;
                if (cnt == CNT_W'(1))
                    nxt = FINISH;
            end
            FINISH: begin
                DONE = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET)
        if (RESET)
            state <= IDLE;
        else
            state <= nxt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            val    <= '0;
            ctl    <= '0;
            acc    <= '0;
            cnt    <= '0;
            sign   <= 1'b0;
            RESULT <= '0;
        end else begin
            if (state == IDLE && START) begin
                val  <= DATA1;
                ctl  <= DATA2;
                acc  <= '0;
                cnt  <= n_load;
                sign <= DATA1[WIDTH-1];
            end else if (state == MUL_RUN) begin
                acc <= acc_nxt;
                val <= val << 1;
                ctl <= ctl >> 1;
                cnt <= cnt - 1'b1;
            end else if (state == SHF_RUN) begin
                val <= step;
                cnt <= cnt - 1'b1;
            end
            if (nxt == FINISH)
                RESULT <= res_nxt;
        end
    end

endmodule

// File: tb/tb_mulshift_sequencer.sv
// tb_mulshift_sequencer: directed table, reset corner case and randomized ops vs. arithmetic model.
module tb_mulshift_sequencer;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic [1:0] OP = 2'b00;
    logic [7:0] DATA1 = 8'h00;
    logic [7:0] DATA2 = 8'h00;
    logic       BUSYWAIT, DONE;
    logic [7:0] RESULT;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] prev_res = 8'h00;

    mulshift_sequencer #(.WIDTH(8)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .START   (START),
        .OP      (OP),
        .DATA1   (DATA1),
        .DATA2   (DATA2),
        .BUSYWAIT(BUSYWAIT),
        .DONE    (DONE),
        .RESULT  (RESULT)
    );

    always #5 CLK = ~CLK;

`ifdef MULSHIFT_EARLY_TERM_EN
    localparam int N03 = 2, N11 = 5, NFF = 8, N06 = 3, N00 = 0;
`else
    localparam int N03 = 8, N11 = 8, NFF = 8, N06 = 8, N00 = 8;
`endif

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        int         n;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    function automatic int model_n(input logic [1:0] op, input logic [7:0] b);
        if (op[1]) return 0;
        if (op == 2'b01) return int'(b[3:0]);
`ifdef MULSHIFT_EARLY_TERM_EN
        for (int i = 7; i >= 0; i--)
            if (b[i]) return i + 1;
        return 0;
`else
        return 8;
`endif
    endfunction

    function automatic logic [7:0] model_res(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int          n;
        int          prod;
        logic [15:0] dbl;
        if (op[1]) return 8'h00;
        if (op == 2'b00) begin
            prod = int'(a) * int'(b);
            return prod[7:0];
        end
        n = int'(b[3:0]);
        case (b[5:4])
            2'b00:   return n >= 8 ? 8'h00 : 8'(a << n);
            2'b01:   return n >= 8 ? 8'h00 : 8'(a >> n);
            2'b10:   return 8'($signed(a) >>> n);
            default: begin
                dbl = {a, a} >> (n % 8);
                return dbl[7:0];
            end
        endcase
    endfunction

    // Caller positions just after a falling edge; returns #1 after the falling
    // edge of the first IDLE cycle following FINISH, with START released.
    task automatic run_op(input int idx, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_res, input int exp_n);
        int         busy, done_cyc;
        logic [7:0] res;
        bit         held;
        busy = 0;
        done_cyc = 0;
        held = 1'b1;
        res = 8'h00;
        OP = op;
        DATA1 = a;
        DATA2 = b;
        START = 1'b1;
        #1;
        for (int c = 1; c <= 40; c++) begin
            if (c == 2) begin
                OP = 2'($urandom);
                DATA1 = 8'($urandom);
                DATA2 = 8'($urandom);
            end
            if (DONE) begin
                done_cyc = c;
                res = RESULT;
                break;
            end
            if (BUSYWAIT) busy++;
            if (RESULT !== prev_res) held = 1'b0;
            @(negedge CLK);
            #1;
        end
        if (done_cyc == 0)
            $display("FAIL done_timeout [%0d]: got no DONE, expected DONE in cycle %0d", idx, exp_n + 2);
        check("result", idx, 32'(res), 32'(exp_res));
        check("busy_cycles", idx, busy, exp_n + 1);
        check("done_cycle", idx, done_cyc, exp_n + 2);
        check("result_held", idx, 32'(held), 32'd1);
        @(negedge CLK);
        START = 1'b0;
        #1;
        check("no_retrigger", idx, {30'd0, BUSYWAIT, DONE}, 32'd0);
        prev_res = exp_res;
    endtask

    initial begin
        logic [1:0] rop;
        logic [7:0] ra, rb;

        tbl[0]  = '{2'b00, 8'h05, 8'h03, 8'h0F, N03};
        tbl[1]  = '{2'b00, 8'h10, 8'h11, 8'h10, N11};
        tbl[2]  = '{2'b00, 8'hFF, 8'hFF, 8'h01, NFF};
        tbl[3]  = '{2'b00, 8'h07, 8'h06, 8'h2A, N06};
        tbl[4]  = '{2'b00, 8'h5A, 8'h00, 8'h00, N00};
        tbl[5]  = '{2'b01, 8'h80, 8'h23, 8'hF0, 3};
        tbl[6]  = '{2'b01, 8'hB7, 8'h09, 8'h00, 9};
        tbl[7]  = '{2'b01, 8'h81, 8'h31, 8'hC0, 1};
        tbl[8]  = '{2'b01, 8'h81, 8'h30, 8'h81, 0};
        tbl[9]  = '{2'b10, 8'hAB, 8'hCD, 8'h00, 0};
        tbl[10] = '{2'b11, 8'hFF, 8'h13, 8'h00, 0};
        tbl[11] = '{2'b01, 8'h96, 8'h1C, 8'h00, 12};
        tbl[12] = '{2'b01, 8'h96, 8'h2F, 8'hFF, 15};
        tbl[13] = '{2'b01, 8'h96, 8'h3A, 8'hA5, 10};

        repeat (2) @(negedge CLK);
        #1;
        check("reset_outputs", 0, {23'd0, BUSYWAIT, DONE, RESULT}, 32'd0);

        @(negedge CLK);
        RESET = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge CLK);
            run_op(i, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].n);
        end

        // Reset in the 4th MUL_RUN cycle, then relaunch with START already held.
        @(negedge CLK);
        OP = 2'b00;
        DATA1 = 8'h33;
        DATA2 = 8'h77;
        START = 1'b1;
        repeat (4) @(negedge CLK);
        #1;
        check("busy_before_reset", 100, 32'(BUSYWAIT), 32'd1);
        START = 1'b0;
        RESET = 1'b1;
        #1;
        check("async_reset_outputs", 100, {23'd0, BUSYWAIT, DONE, RESULT}, 32'd0);
        prev_res = 8'h00;
        OP = 2'b00;
        DATA1 = 8'h07;
        DATA2 = 8'h06;
        START = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        run_op(101, 2'b00, 8'h07, 8'h06, 8'h2A, N06);

        for (int i = 0; i < 200; i++) begin
            rop = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            ra = 8'($urandom);
            rb = 8'($urandom);
            @(negedge CLK);
            run_op(200 + i, rop, ra, rb, model_res(rop, ra, rb), model_n(rop, rb));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
